// File: rtl/ahb_csr_bank.sv
// ahb_csr_bank: AHB-Lite slave exposing a RW control bank and a RO status bank.
// Optional macro CSR_BANK_ERR_RESP_EN enables the two-cycle ERROR response on illegal access.

module ahb_csr_reg #(
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] q,
    output logic        pulse
);
    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= RESET_VAL;
            pulse <= 1'b0;
        end else begin
            pulse <= we;
            for (int b = 0; b < 4; b++)
                if (we && be[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end
endmodule

module ahb_csr_bank #(
    parameter int unsigned RW_REG_CNT   = 16,
    parameter int unsigned R_REG_CNT    = 16,
    parameter int unsigned R_BANK_BIT   = 19,
    parameter logic [31:0] RW_RESET_VAL = 32'h0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 ahb_s0_haddr_i,
    input  logic                        ahb_s0_hwrite_i,
    input  logic [2:0]                  ahb_s0_hsize_i,
    input  logic [1:0]                  ahb_s0_htrans_i,
    input  logic [31:0]                 ahb_s0_hwdata_i,
    output logic                        ahb_s0_hready_o,
    output logic                        ahb_s0_hresp_o,
    output logic [31:0]                 ahb_s0_hrdata_o,
    output logic [RW_REG_CNT-1:0][31:0] rw_reg,
    output logic [RW_REG_CNT-1:0]       rw_wr_pulse,
    input  logic [R_REG_CNT-1:0][31:0]  r_reg,
    output logic [R_REG_CNT-1:0]        r_rd_pulse
);
    typedef enum logic [1:0] {NONE, OK, ERR1, ERR2} state_t;
    state_t state, state_nxt;

    logic                 accept, a_rbank, a_legal, a_aligned;
    logic [31:0]          a_idx;
    logic [3:0]           a_be;
    logic                 dp_write;
    logic [7:0]           dp_idx;
    logic [3:0]           dp_be;
    logic                 commit, fwd_hit;
    logic [31:0]          rw_rd, r_rd, rd_merged;
    logic [R_REG_CNT-1:0] r_sel;
    logic                 unused_htrans0;

    assign unused_htrans0 = ahb_s0_htrans_i[0];

    // Address-phase decode
    always_comb begin
        accept  = ahb_s0_htrans_i[1] && ahb_s0_hready_o;
        a_rbank = ahb_s0_haddr_i[R_BANK_BIT];
        a_idx   = 32'(ahb_s0_haddr_i[R_BANK_BIT-1:2]);
        case (ahb_s0_hsize_i)
            3'd0:    a_be = 4'b0001 << ahb_s0_haddr_i[1:0];
            3'd1:    a_be = ahb_s0_haddr_i[1] ? 4'b1100 : 4'b0011;
            default: a_be = 4'b1111;
        endcase
        a_aligned = (ahb_s0_hsize_i == 3'd0)
                 || (ahb_s0_hsize_i == 3'd1 && !ahb_s0_haddr_i[0])
                 || (ahb_s0_hsize_i == 3'd2 && ahb_s0_haddr_i[1:0] == 2'b00);
        a_legal = ((ahb_s0_haddr_i >> (R_BANK_BIT + 1)) == 32'd0)
               && (a_rbank ? (a_idx < R_REG_CNT) : (a_idx < RW_REG_CNT))
               && (ahb_s0_hsize_i <= 3'd2) && a_aligned
               && !(a_rbank && ahb_s0_hwrite_i);
    end

    // Only a legal data phase reaches OK, so OK plus a captured write means commit now
    assign commit = (state == OK) && dp_write;

    always_comb begin
        rw_rd = '0;
        r_rd  = '0;
        r_sel = '0;
        for (int i = 0; i < RW_REG_CNT; i++)
            if (a_idx == 32'(i)) rw_rd = rw_reg[i];
        for (int i = 0; i < R_REG_CNT; i++) begin
            r_sel[i] = (a_idx == 32'(i));
            if (r_sel[i]) r_rd = r_reg[i];
        end
    end

    // Read hitting the register being written this cycle sees the merged value
    always_comb begin
        fwd_hit   = commit && !a_rbank && (a_idx == 32'(dp_idx));
        rd_merged = rw_rd;
        for (int b = 0; b < 4; b++)
            if (fwd_hit && dp_be[b]) rd_merged[b*8 +: 8] = ahb_s0_hwdata_i[b*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dp_write        <= 1'b0;
            dp_idx          <= '0;
            dp_be           <= '0;
            ahb_s0_hrdata_o <= '0;
            r_rd_pulse      <= '0;
        end else begin
            r_rd_pulse <= '0;
            if (accept) begin
                dp_write <= ahb_s0_hwrite_i;
                dp_idx   <= a_idx[7:0];
                dp_be    <= a_be;
                if (!ahb_s0_hwrite_i) begin
                    if (!a_legal) begin
                        ahb_s0_hrdata_o <= '0;
                    end else if (a_rbank) begin
                        ahb_s0_hrdata_o <= r_rd;
                        r_rd_pulse      <= r_sel;
                    end else begin
                        ahb_s0_hrdata_o <= rd_merged;
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < RW_REG_CNT; i++) begin : g_rw
        ahb_csr_reg #(.RESET_VAL(RW_RESET_VAL)) u_reg (
            .clk   (clk),
            .reset (reset),
            .we    (commit && (dp_idx == 8'(i))),
            .be    (dp_be),
            .wdata (ahb_s0_hwdata_i),
            .q     (rw_reg[i]),
            .pulse (rw_wr_pulse[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) state <= NONE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = NONE;
        case (state)
`ifdef CSR_BANK_ERR_RESP_EN
            ERR1:    state_nxt = ERR2;
            default: if (accept) state_nxt = a_legal ? OK : ERR1;
`else
            default: if (accept && a_legal) state_nxt = OK;
`endif
        endcase
    end

    always_comb begin
`ifdef CSR_BANK_ERR_RESP_EN
        ahb_s0_hready_o = (state != ERR1);
        ahb_s0_hresp_o  = (state == ERR1) || (state == ERR2);
`else
        ahb_s0_hready_o = 1'b1;
        ahb_s0_hresp_o  = 1'b0;
`endif
    end
endmodule

// File: tb/tb_ahb_csr_bank.sv
// tb_ahb_csr_bank: directed plus randomized AHB traffic checked each cycle against a
// transaction-level model of the register bank.
module tb_ahb_csr_bank;
    localparam int          N    = 16;
    localparam logic [31:0] BANK = 32'h0008_0000;
`ifdef CSR_BANK_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [31:0]        haddr = '0, hwdata = '0, hrdata;
    logic               hwrite = 1'b0, hready, hresp;
    logic [2:0]         hsize = '0;
    logic [1:0]         htrans = '0;
    logic [N-1:0][31:0] rw_reg, r_reg;
    logic [N-1:0]       rw_wr_pulse, r_rd_pulse;
    logic [31:0]        nxt_wdata = '0;
    int                 n_vec = 0, n_err = 0;

    ahb_csr_bank #(
        .RW_REG_CNT(N), .R_REG_CNT(N), .R_BANK_BIT(19), .RW_RESET_VAL(32'h0)
    ) u_dut (
        .clk(clk), .reset(reset),
        .ahb_s0_haddr_i(haddr), .ahb_s0_hwrite_i(hwrite), .ahb_s0_hsize_i(hsize),
        .ahb_s0_htrans_i(htrans), .ahb_s0_hwdata_i(hwdata),
        .ahb_s0_hready_o(hready), .ahb_s0_hresp_o(hresp), .ahb_s0_hrdata_o(hrdata),
        .rw_reg(rw_reg), .rw_wr_pulse(rw_wr_pulse), .r_reg(r_reg), .r_rd_pulse(r_rd_pulse)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_rw [N];
    logic [31:0] e_rdata, dp_addr;
    logic [N-1:0] e_wr, e_rd;
    bit e_ready, e_resp, dp_vld, dp_ok, dp_wr, model_ok = 1'b0;
    int err_ph, dp_size, mi, lo;

    function automatic bit legal(input logic [31:0] a, input bit w, input int sz);
        if (a >= 2 * BANK) return 1'b0;
        if (sz > 2) return 1'b0;
        if (a % (1 << sz) != 0) return 1'b0;
        if ((a % BANK) / 4 >= N) return 1'b0;
        if (a >= BANK && w) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) m_rw[i] = 32'h0;
            e_rdata = '0; e_wr = '0; e_rd = '0;
            err_ph = 0; dp_vld = 1'b0; model_ok = 1'b1;
        end else begin
            e_wr = '0;
            e_rd = '0;
            // pending data phase completes at this edge, before any new read is looked up
            if (dp_vld && dp_ok && dp_wr) begin
                mi = int'(dp_addr / 4);
                lo = int'(dp_addr % 4);
                for (int b = 0; b < 4; b++)
                    if (b >= lo && b < lo + (1 << dp_size)) m_rw[mi][b*8 +: 8] = hwdata[b*8 +: 8];
                e_wr[mi] = 1'b1;
            end
            dp_vld = 1'b0;
            if (err_ph == 1) begin
                err_ph = 2;
            end else begin
                err_ph = 0;
                if (htrans[1]) begin
                    dp_vld  = 1'b1;
                    dp_ok   = legal(haddr, hwrite, int'(hsize));
                    dp_wr   = hwrite;
                    dp_addr = haddr;
                    dp_size = int'(hsize);
                    mi      = int'((haddr % BANK) / 4);
                    if (!hwrite) begin
                        if (!dp_ok) e_rdata = '0;
                        else if (haddr >= BANK) begin e_rdata = r_reg[mi]; e_rd[mi] = 1'b1; end
                        else e_rdata = m_rw[mi];
                    end
                    if (!dp_ok && ERR_EN) err_ph = 1;
                end
            end
        end
        e_ready = (err_ph != 1);
        e_resp  = (err_ph != 0);
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("hready", 32'(hready), 32'(e_ready));
            chk("hresp", 32'(hresp), 32'(e_resp));
            chk("hrdata", hrdata, e_rdata);
            chk("rw_wr_pulse", 32'(rw_wr_pulse), 32'(e_wr));
            chk("r_rd_pulse", 32'(r_rd_pulse), 32'(e_rd));
            for (int i = 0; i < N; i++) chk($sformatf("rw_reg[%0d]", i), rw_reg[i], m_rw[i]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit vld, input logic [31:0] a, input bit w,
                         input logic [2:0] sz, input logic [31:0] wd, input bit seq);
        @(posedge clk); #1;
        hwdata = nxt_wdata;
        if (vld && hready) begin
            htrans = seq ? 2'b11 : 2'b10;
            haddr = a; hwrite = w; hsize = sz; nxt_wdata = wd;
        end else begin
            htrans = 2'b00;
        end
    endtask

    logic [31:0] vals [4];
    logic [31:0] ra;
    logic [2:0]  rsz;
    int          sel;

    initial begin
        vals[0] = 32'h1111_0001; vals[1] = 32'h2222_0002;
        vals[2] = 32'h3333_0003; vals[3] = 32'h4444_0004;
        for (int i = 0; i < N; i++) r_reg[i] = 32'h0;
        reset = 1'b1;
        repeat (2) drive(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0); #2;
        chk("rst_hready", 32'(hready), 32'h1);
        chk("rst_hresp", 32'(hresp), 32'h0);
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_rw_reg7", rw_reg[7], 32'h0);

        // word write, visible the cycle after its data phase
        drive(1, 32'h8, 1, 2, 32'hDEAD_BEEF, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0); #2;
        chk("wr_rw2", rw_reg[2], 32'hDEAD_BEEF);
        chk("wr_pulse", 32'(rw_wr_pulse), 32'h4);

        // byte write followed immediately by a read of the same word
        drive(1, 32'h9, 1, 0, 32'h0000_5500, 0);
        drive(1, 32'h8, 0, 2, 0, 1);
        drive(0, 0, 0, 0, 0, 0); #2;
        chk("fwd_hrdata", hrdata, 32'hDEAD_55EF);
        chk("fwd_rw2", rw_reg[2], 32'hDEAD_55EF);

        // status read, then an illegal write to the status bank
        r_reg[3] = 32'h1234_5678;
        drive(1, 32'h0008_000C, 0, 2, 0, 0);
        drive(0, 0, 0, 0, 0, 0); #2;
        chk("r3_hrdata", hrdata, 32'h1234_5678);
        chk("r3_pulse", 32'(r_rd_pulse), 32'h8);
        drive(1, 32'h0008_000C, 1, 2, 32'hFFFF_FFFF, 0);
        drive(0, 0, 0, 0, 0, 0); #2;
        chk("rwr_hready1", 32'(hready), 32'(!ERR_EN));
        chk("rwr_hresp1", 32'(hresp), 32'(ERR_EN));
        chk("rwr_rdpulse", 32'(r_rd_pulse), 32'h0);
        chk("rwr_hrdata", hrdata, 32'h1234_5678);
        drive(0, 0, 0, 0, 0, 0); #2;
        chk("rwr_hready2", 32'(hready), 32'h1);
        chk("rwr_hresp2", 32'(hresp), 32'(ERR_EN));
        chk("rwr_wrpulse", 32'(rw_wr_pulse), 32'h0);

        // out-of-range RW index
        drive(1, 32'h40, 0, 2, 0, 0);
        drive(0, 0, 0, 0, 0, 0); #2;
        chk("oor_hrdata", hrdata, 32'h0);
        chk("oor_hready", 32'(hready), 32'(!ERR_EN));
        chk("oor_hresp", 32'(hresp), 32'(ERR_EN));
        drive(0, 0, 0, 0, 0, 0); #2;
        chk("oor_hready2", 32'(hready), 32'h1);

        // four back-to-back writes, four back-to-back reads
        for (int k = 0; k < 4; k++) drive(1, 32'(k * 4), 1, 2, vals[k], k != 0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'(k * 4), 0, 2, 0, 1); #2;
            chk("b2b_hready", 32'(hready), 32'h1);
            if (k > 0) chk($sformatf("b2b_rd%0d", k - 1), hrdata, vals[k-1]);
        end
        drive(0, 0, 0, 0, 0, 0); #2;
        chk("b2b_rd3", hrdata, vals[3]);

        // reset lands on the data phase of the third write
        drive(1, 32'h10, 1, 2, 32'hA5A5_0004, 0);
        drive(1, 32'h14, 1, 2, 32'hA5A5_0005, 1);
        drive(1, 32'h18, 1, 2, 32'hA5A5_0006, 1);
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b0; #2;
        for (int i = 0; i < N; i++) chk($sformatf("rst_mid_rw%0d", i), rw_reg[i], 32'h0);
        chk("rst_mid_pulse", 32'(rw_wr_pulse), 32'h0);

        // randomized traffic
        for (int t = 0; t < 700; t++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2: ra = $urandom_range(0, 3) * 4 + $urandom_range(0, 3);
                3, 4, 5: ra = $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
                6, 7:    ra = BANK + $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
                8:       ra = ($urandom_range(0, 1) ? BANK : 32'h0) + $urandom_range(16, 24) * 4;
                default: ra = (32'h0010_0000 << $urandom_range(0, 11)) | $urandom_range(0, 63);
            endcase
            rsz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            drive($urandom_range(0, 4) != 0, ra, 1'($urandom_range(0, 1)), rsz, $urandom,
                  1'($urandom_range(0, 1)));
            for (int i = 0; i < N; i++) r_reg[i] = $urandom;
            reset = ($urandom_range(0, 99) == 0);
        end
        reset = 1'b0;
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
